// File: rtl/ins_loader_pkg.sv
// Shared definitions for the instruction loader: opcodes, instruction word layout and FSM encoding.
package ins_loader_pkg;

    localparam int INS_AW   = 4;
    localparam int DEPTH    = 2 ** INS_AW;
    localparam int SZB_INS  = 16;
    localparam int BIT_INST = 12;
    localparam int CNT_W    = 5;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    localparam logic [3:0] OP_LD_INS  = 4'h2;
    localparam logic [3:0] OP_IO_IDLE = 4'hF;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_DATA = 3'd1;
    localparam logic [2:0] ST_ISSUE     = 3'd2;
    localparam logic [2:0] ST_SETTLE    = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_WAIT_DATA = ST_WAIT_DATA,
        S_ISSUE     = ST_ISSUE,
        S_SETTLE    = ST_SETTLE,
        S_DONE      = ST_DONE
    } loader_state_e;

    // Instruction the controller decodes as "no IO action".
    localparam logic [SZB_INS-1:0] INS_IDLE = {OP_IO_IDLE, {BIT_INST{1'b0}}};

    function automatic logic [SZB_INS-1:0] ld_ins_word(input logic [INS_AW-1:0] addr);
        return {OP_LD_INS, addr, {(BIT_INST-INS_AW){1'b0}}};
    endfunction

    // Loads longer than the memory are truncated so the address never wraps.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] wc);
        return (wc > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : wc;
    endfunction

endpackage

// File: rtl/ins_loader_if.sv
// Host stream plus controller-side buses of the instruction loader.
// Optional checksum signal present when INS_LOADER_CHECKSUM_EN is defined.
interface ins_loader_if;
    import ins_loader_pkg::*;

    // s_data is transferred on a cycle where s_valid and s_ready are both high at the
    // clock edge; the host holds s_data stable while s_valid is high and s_ready is low.
    logic               start;
    logic [CNT_W-1:0]   word_count;
    logic               s_valid;
    logic [SZB_INS-1:0] s_data;
    logic               s_ready;
    logic               interrupt;
    logic [SZB_INS-1:0] instructions;
    logic [SZB_INS-1:0] io_data;
    logic               busy;
    logic               done;
`ifdef INS_LOADER_CHECKSUM_EN
    logic [SZB_INS-1:0] checksum;

    modport master (
        output start, word_count, s_valid, s_data,
        input  s_ready, interrupt, instructions, io_data, busy, done, checksum
    );
    modport slave (
        input  start, word_count, s_valid, s_data,
        output s_ready, interrupt, instructions, io_data, busy, done, checksum
    );
`else
    modport master (
        output start, word_count, s_valid, s_data,
        input  s_ready, interrupt, instructions, io_data, busy, done
    );
    modport slave (
        input  start, word_count, s_valid, s_data,
        output s_ready, interrupt, instructions, io_data, busy, done
    );
`endif

endinterface

// File: rtl/ins_loader.sv
// Loads a host word stream into instruction memory via one LD_INS per word through the controller.
// Build option INS_LOADER_CHECKSUM_EN adds a byte-swapped XOR checksum of the loaded words.
module ins_loader
    import ins_loader_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    ins_loader_if.slave   bus,
    output loader_state_e dbg_state_o
);

    loader_state_e      state_q, state_d;
    logic [INS_AW-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               s_ready_q, s_ready_d;
    logic               interrupt_q, interrupt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [SZB_INS-1:0] instructions_q, instructions_d;
    logic [SZB_INS-1:0] io_data_q, io_data_d;
`ifdef INS_LOADER_CHECKSUM_EN
    logic [SZB_INS-1:0] checksum_q, checksum_d;
`endif

    logic accept;
    assign accept = bus.s_valid && s_ready_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            remaining_q    <= '0;
            s_ready_q      <= OFF;
            interrupt_q    <= OFF;
            busy_q         <= OFF;
            done_q         <= OFF;
            instructions_q <= '0;
            io_data_q      <= '0;
`ifdef INS_LOADER_CHECKSUM_EN
            checksum_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            remaining_q    <= remaining_d;
            s_ready_q      <= s_ready_d;
            interrupt_q    <= interrupt_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            instructions_q <= instructions_d;
            io_data_q      <= io_data_d;
`ifdef INS_LOADER_CHECKSUM_EN
            checksum_q     <= checksum_d;
`endif
        end
    end

    // Every output is a register; the _d values are what the outputs show in the next state.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        remaining_d    = remaining_q;
        s_ready_d      = s_ready_q;
        interrupt_d    = interrupt_q;
        busy_d         = busy_q;
        done_d         = OFF;
        instructions_d = instructions_q;
        io_data_d      = io_data_q;
`ifdef INS_LOADER_CHECKSUM_EN
        checksum_d     = checksum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
`ifdef INS_LOADER_CHECKSUM_EN
                    checksum_d = '0;
`endif
                    if (bus.word_count == '0) begin
                        state_d = S_DONE;
                        done_d  = ON;
                    end else begin
                        state_d        = S_WAIT_DATA;
                        remaining_d    = clamp_count(bus.word_count);
                        addr_d         = '0;
                        busy_d         = ON;
                        interrupt_d    = ON;
                        s_ready_d      = ON;
                        instructions_d = INS_IDLE;
                    end
                end
            end
            S_WAIT_DATA: begin
                if (accept) begin
                    io_data_d      = bus.s_data;
                    instructions_d = ld_ins_word(addr_q);
                    s_ready_d      = OFF;
                    state_d        = S_ISSUE;
`ifdef INS_LOADER_CHECKSUM_EN
                    checksum_d     = checksum_q ^ {bus.s_data[7:0], bus.s_data[15:8]};
`endif
                end
            end
            S_ISSUE: begin
                // The controller has latched the write request; io_data stays put for the write.
                instructions_d = INS_IDLE;
                state_d        = S_SETTLE;
            end
            S_SETTLE: begin
                addr_d      = addr_q + INS_AW'(1);
                remaining_d = remaining_q - CNT_W'(1);
                if (remaining_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    done_d  = ON;
                end else begin
                    state_d   = S_WAIT_DATA;
                    s_ready_d = ON;
                end
            end
            S_DONE: begin
                state_d        = S_IDLE;
                interrupt_d    = OFF;
                busy_d         = OFF;
                s_ready_d      = OFF;
                instructions_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.s_ready      = s_ready_q;
    assign bus.interrupt    = interrupt_q;
    assign bus.instructions = instructions_q;
    assign bus.io_data      = io_data_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
`ifdef INS_LOADER_CHECKSUM_EN
    assign bus.checksum     = checksum_q;
`endif
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_ins_loader.sv
// Bench for ins_loader: table of load shapes, hand sequences for reset/abort, randomized loads
// against a word-queue reference and a small model of the controller's instruction-memory write.
module tb_ins_loader;
    import ins_loader_pkg::*;

    logic          clock = 1'b0;
    logic          reset;
    loader_state_e dbg_state;

    ins_loader_if bus();

    ins_loader dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clock = ~clock;

    // Controller stand-in: registers the write request, writes memory one cycle later.
    logic [15:0] imem [DEPTH];
    logic        ins_we_m;
    logic [3:0]  addr_m;
    int          wr_cnt = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            ins_we_m <= 1'b0;
            addr_m   <= 4'h0;
        end else begin
            if (ins_we_m) begin
                imem[addr_m] <= bus.io_data;
                wr_cnt       <= wr_cnt + 1;
            end
            ins_we_m <= bus.interrupt && (bus.instructions[15:12] == OP_LD_INS);
            addr_m   <= bus.instructions[11:8];
        end
    end

    // Scoreboard
    logic [15:0] exp_q[$];
    logic [15:0] fixed_words[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Runs one load. stall<0 picks a random stall (0..3) per word. abort_at>0 pulses reset
    // in that cycle and returns early.
    task automatic run_load(input int wc, input int stall, input int abort_at, output int cycles);
        int n = (wc > DEPTH) ? DEPTH : wc;
        int stall_k;
        int stall_cnt = 0;
        int ld_seen = 0;
        int hs = 0;
        int exp_cycles = 1;
        int wr_base;
        logic saw_int = 1'b0;
        logic done_seen = 1'b0;
        logic [15:0] cur_word;
        logic [15:0] last_word = 16'h0;
        logic [15:0] cs_model = 16'h0;
        wr_base = wr_cnt;
        exp_q.delete();
        stall_k = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        if (fixed_words.size() > 0) cur_word = fixed_words.pop_front();
        else cur_word = 16'($urandom);
        @(negedge clock);
        bus.start      = 1'b1;
        bus.word_count = wc[4:0];
        cycles = 0;
        while (!done_seen && cycles < 300) begin
            @(negedge clock);
            cycles++;
            bus.start = 1'b0;
            if (bus.interrupt) saw_int = 1'b1;
            if (bus.instructions[15:12] == OP_LD_INS) begin
                check("ld_ins_word", bus.instructions, {4'h2, ld_seen[3:0], 8'h00});
                check("io_data_at_issue", bus.io_data, last_word);
                ld_seen++;
            end
            if (abort_at > 0 && cycles == abort_at) begin
                bus.s_valid = 1'b0;
                #1 reset = 1'b1;
                #1 check("reset_async", {bus.interrupt, bus.busy, bus.s_ready, bus.done, bus.instructions}, 64'h0);
                @(negedge clock);
                @(negedge clock);
                reset = 1'b0;
                return;
            end
            if (bus.done) begin
                done_seen = 1'b1;
                bus.s_valid = 1'b0;
            end else if (bus.s_ready) begin
                if (stall_cnt < stall_k) begin
                    check("stall_hold", {bus.interrupt, ins_we_m, bus.instructions}, {1'b1, 1'b0, 16'hF000});
                    bus.s_valid = 1'b0;
                    stall_cnt++;
                end else begin
                    bus.s_valid = 1'b1;
                    bus.s_data  = cur_word;
                    exp_q.push_back(cur_word);
                    cs_model   = cs_model ^ {cur_word[7:0], cur_word[15:8]};
                    last_word  = cur_word;
                    exp_cycles += 3 + stall_k;
                    hs++;
                    stall_cnt  = 0;
                    stall_k    = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
                    if (fixed_words.size() > 0) cur_word = fixed_words.pop_front();
                    else cur_word = 16'($urandom);
                end
            end else begin
                // Outside WAIT_DATA the loader must ignore the stream entirely.
                bus.s_valid = 1'($urandom_range(0, 1));
                bus.s_data  = 16'($urandom);
            end
            if (cycles == 2 && n > 0) bus.start = 1'($urandom_range(0, 1));
        end
        bus.s_valid = 1'b0;
        fixed_words.delete();
        check("done_seen", done_seen, 1'b1);
        check("interrupt_seen", saw_int, (n > 0));
        check("ld_count", ld_seen, n);
        check("handshakes", hs, n);
        check("cycles_model", cycles, exp_cycles);
        check("done_flags", {bus.busy, bus.interrupt, bus.s_ready}, {(n > 0), (n > 0), 1'b0});
`ifdef INS_LOADER_CHECKSUM_EN
        check("checksum_model", bus.checksum, cs_model);
`endif
        check("write_count", wr_cnt - wr_base, n);
        for (int i = 0; i < n; i++) begin
            check("imem_word", imem[i], exp_q.pop_front());
        end
        @(negedge clock);
        check("done_pulse", {bus.done, bus.busy, bus.interrupt, bus.instructions}, 64'h0);
    endtask

    typedef struct {
        int wc;
        int stall;
        int exp_cycles;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int base;
        logic [15:0] old1;

        vecs[0] = '{3, 0, 10};
        vecs[1] = '{0, 0, 1};
        vecs[2] = '{2, 5, 17};
        vecs[3] = '{1, 0, 4};
        vecs[4] = '{16, 0, 49};
        vecs[5] = '{20, 0, 49};
        vecs[6] = '{5, 2, 26};
        vecs[7] = '{1, 3, 7};

        // Clock/reset
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.word_count = 5'd0;
        bus.s_valid    = 1'b0;
        bus.s_data     = 16'h0;
        repeat (3) @(negedge clock);
        check("reset_state", 64'(dbg_state), 64'(S_IDLE));
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("idle_outputs", {bus.interrupt, bus.busy, bus.s_ready, bus.done, bus.instructions, bus.io_data}, 64'h0);
        end

        // Three known words, s_valid held high: done 9 cycles after the first accept.
        fixed_words = '{16'hA123, 16'h4B56, 16'h7C89};
        run_load(3, 0, 0, cyc);
        check("seq3_cycles", cyc, 10);
        check("seq3_imem0", imem[0], 16'hA123);
        check("seq3_imem1", imem[1], 16'h4B56);
        check("seq3_imem2", imem[2], 16'h7C89);

        for (int v = 0; v < 8; v++) begin
            run_load(vecs[v].wc, vecs[v].stall, 0, cyc);
            check("table_cycles", cyc, vecs[v].exp_cycles);
        end

        // Reset during SETTLE of the second word of four.
        base = wr_cnt;
        old1 = imem[1];
        fixed_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        run_load(4, 0, 6, cyc);
        fixed_words.delete();
        check("abort_writes", wr_cnt - base, 1);
        check("abort_imem0", imem[0], 16'h1111);
        check("abort_imem1_kept", imem[1], old1);
        run_load(3, 0, 0, cyc);
        check("after_abort_cycles", cyc, 10);

`ifdef INS_LOADER_CHECKSUM_EN
        fixed_words = '{16'h1234, 16'h00FF};
        run_load(2, 0, 0, cyc);
        check("checksum_const", bus.checksum, 16'hCB12);
`endif

        for (int r = 0; r < 25; r++) begin
            run_load(int'($urandom_range(0, 20)), -1, 0, cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
